// File: rtl/letter_ps2_pkg.sv
// Shared constants, state encodings and the letter-to-scan-code table
// for the PS/2 keystroke transmitter.
package letter_ps2_pkg;

   localparam int         FRAME_LEN    = 11;
   localparam logic [7:0] BREAK_PREFIX = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BIT_HI,
      ST_BIT_LO
   } ps2_state_t;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_SEND,
      SEQ_GAP
   } seq_state_t;

   typedef struct packed {
      logic       ok;
      logic [7:0] code;
   } scan_t;

   // Set-2 make codes, A=1 .. Z=26; anything else is flagged invalid.
   function automatic scan_t scan_lookup(input logic [4:0] letter);
      scan_t r;
      r.ok = 1'b1;
      case (letter)
         5'd1:  r.code = 8'h1C;
         5'd2:  r.code = 8'h32;
         5'd3:  r.code = 8'h21;
         5'd4:  r.code = 8'h23;
         5'd5:  r.code = 8'h24;
         5'd6:  r.code = 8'h2B;
         5'd7:  r.code = 8'h34;
         5'd8:  r.code = 8'h33;
         5'd9:  r.code = 8'h43;
         5'd10: r.code = 8'h3B;
         5'd11: r.code = 8'h42;
         5'd12: r.code = 8'h4B;
         5'd13: r.code = 8'h3A;
         5'd14: r.code = 8'h31;
         5'd15: r.code = 8'h44;
         5'd16: r.code = 8'h4D;
         5'd17: r.code = 8'h15;
         5'd18: r.code = 8'h2D;
         5'd19: r.code = 8'h1B;
         5'd20: r.code = 8'h2C;
         5'd21: r.code = 8'h3C;
         5'd22: r.code = 8'h2A;
         5'd23: r.code = 8'h1D;
         5'd24: r.code = 8'h22;
         5'd25: r.code = 8'h35;
         5'd26: r.code = 8'h1A;
         default: begin
            r.ok   = 1'b0;
            r.code = 8'h00;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_byte_ser.sv
// Single-byte PS/2 device-to-host serializer: start, 8 data LSB first,
// odd parity, stop. Each bit is a high half then a low half of CLK_DIV cycles.
//
// state     | meaning
// ST_IDLE   | lines high, waiting for start
// ST_BIT_HI | clock high, data presents current frame bit
// ST_BIT_LO | clock low, data held for the host to sample
module ps2_byte_ser
   import letter_ps2_pkg::*;
#(
   parameter int CLK_DIV = 2500
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] tx_byte,
   output logic       done,
   output logic       ps2_clk,
   output logic       ps2_data
);

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [3:0]  BIT_LAST = 4'(FRAME_LEN - 1);

   ps2_state_t             state, state_nxt;
   logic [15:0]            div_cnt;
   logic [3:0]             bit_cnt;
   logic [FRAME_LEN-1:0]   frame;
   logic                   phase_end;

   assign phase_end = (div_cnt == DIV_LAST);

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_BIT_HI;
         ST_BIT_HI: if (phase_end) state_nxt = ST_BIT_LO;
         ST_BIT_LO: begin
            if (phase_end) begin
               if (bit_cnt == BIT_LAST) begin
                  done      = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_BIT_HI;
               end
            end
         end
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         frame   <= '1;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            if (start) frame <= {1'b1, ~^tx_byte, tx_byte, 1'b0};
         end else if (phase_end) begin
            div_cnt <= '0;
            // Bit index only advances on the low-to-high transition so data never moves while clock is low.
            if (state == ST_BIT_LO && bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + 4'd1;
         end else begin
            div_cnt <= div_cnt + 16'd1;
         end
      end
   end

   assign ps2_clk  = (state != ST_BIT_LO);
   assign ps2_data = (state == ST_IDLE) ? 1'b1 : frame[bit_cnt];

endmodule

// File: rtl/letter_ps2_tx.sv
// Letter-to-keystroke transmitter: looks up the make code and sends
// make, break prefix, make as three PS/2 frames separated by idle gaps.
//
// state    | meaning
// SEQ_IDLE | ready, waiting for a letter
// SEQ_SEND | serializer shifting byte number byte_cnt
// SEQ_GAP  | lines idle for GAP_CYC cycles between bytes
module letter_ps2_tx
   import letter_ps2_pkg::*;
#(
   parameter int CLK_DIV = 2500,
   parameter int GAP_CYC = 5000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] letter,
   input  logic       valid,
   output logic       ready,
   output logic       busy,
   output logic       err,
   output logic       ps2_clk_o,
   output logic       ps2_data_o
);

   localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

   seq_state_t  state, state_nxt;
   scan_t       lut;
   logic [7:0]  code;
   logic [1:0]  byte_cnt;
   logic [15:0] gap_cnt;
   logic        accept;
   logic        ser_start;
   logic        ser_done;
   logic [7:0]  ser_byte;

   assign lut    = scan_lookup(letter);
   assign ready  = (state == SEQ_IDLE);
   assign busy   = ~ready;
   assign accept = valid && ready;

   // The first byte goes straight from the lookup so the start bit appears on the acceptance edge.
   assign ser_byte = (state == SEQ_IDLE) ? lut.code :
                     (byte_cnt == 2'd0)  ? BREAK_PREFIX : code;

   always_comb begin
      state_nxt = state;
      ser_start = 1'b0;
      case (state)
         SEQ_IDLE: begin
            if (accept && lut.ok) begin
               state_nxt = SEQ_SEND;
               ser_start = 1'b1;
            end
         end
         SEQ_SEND: if (ser_done) state_nxt = (byte_cnt == 2'd2) ? SEQ_IDLE : SEQ_GAP;
         SEQ_GAP: begin
            if (gap_cnt == 16'd0) begin
               state_nxt = SEQ_SEND;
               ser_start = 1'b1;
            end
         end
         default: state_nxt = SEQ_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= SEQ_IDLE;
         code     <= '0;
         byte_cnt <= '0;
         gap_cnt  <= '0;
         err      <= 1'b0;
      end else begin
         state <= state_nxt;
         err   <= accept && !lut.ok;
         case (state)
            SEQ_IDLE: begin
               if (accept && lut.ok) begin
                  code     <= lut.code;
                  byte_cnt <= '0;
               end
            end
            SEQ_SEND: begin
               if (ser_done) begin
                  if (byte_cnt == 2'd2) byte_cnt <= '0;
                  else                  gap_cnt  <= GAP_LAST;
               end
            end
            SEQ_GAP: begin
               if (gap_cnt == 16'd0) byte_cnt <= byte_cnt + 2'd1;
               else                  gap_cnt  <= gap_cnt - 16'd1;
            end
            default: ;
         endcase
      end
   end

   ps2_byte_ser #(.CLK_DIV(CLK_DIV)) u_ser (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (ser_start),
      .tx_byte  (ser_byte),
      .done     (ser_done),
      .ps2_clk  (ps2_clk_o),
      .ps2_data (ps2_data_o)
   );

endmodule

// File: doc/letter_ps2_tx.md
Name: letter_ps2_tx

Overview:
- Encoder and transmitter for the keyboard path: takes a letter index 1..26 (A=1 … Z=26) and emits it as a PS/2 device-to-host key press and release.
- Each press/release is a make code, a break prefix 8'hF0, then the make code again.
- Drives the lines a host-side PS/2 receiver and scan-code decoder consume, e.g. for Enigma loopback test or for feeding ciphertext letters back as keystrokes.

Parameters:
- CLK_DIV, 2500: system-clock cycles per PS/2 clock half-period (2500 at 100 MHz gives 20 kHz); legal range 2..65535.
- GAP_CYC, 5000: idle cycles (both lines high) between consecutive bytes of one keystroke; legal range 1..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- letter  in  5  letter index; only 1..26 is valid.
- valid  in  1  request strobe; accepted on a cycle with valid && ready.
- ready  out  1  high when idle and able to accept.
- busy  out  1  high while a keystroke sequence is in progress (equals ~ready).
- err  out  1  one-cycle pulse when an invalid letter (0 or 27..31) is offered and accepted.
- ps2_clk_o  out  1  PS/2 clock level; idles high.
- ps2_data_o  out  1  PS/2 data level; idles high.

Behaviour:
- Reset (async assert, sync release): ps2_clk_o=1, ps2_data_o=1, ready=1, busy=0, err=0, FSM=IDLE, all counters 0.
- Reset mid-frame aborts immediately: lines go high, and no partial byte is resumed after release.
- Scan code table, fixed, for letters 1..26 (A..Z): 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
- Acceptance with a valid letter:
  - The code is latched and ready drops on the next edge.
  - The byte sequence is {code, F0, code}.
  - Later changes on letter/valid have no effect.
- Acceptance with an invalid letter: err=1 for exactly the following cycle, ready stays 1, and the lines stay idle.
- valid while ready=0 is ignored: no queueing, no err.
- Frame format, 11 bits: start 0, data bits b0..b7 (LSB first), odd parity = ~^byte, stop 1.
- FSM states:
  - IDLE → BIT_HI on a valid acceptance.
  - BIT_HI: ps2_clk_o=1, ps2_data_o=current bit, held for CLK_DIV cycles → BIT_LO.
  - BIT_LO: ps2_clk_o=0, data held, for CLK_DIV cycles. Then, if bit<10, bit++ and go to BIT_HI. If bit==10 and byte<2, go to GAP. If bit==10 and byte==2, go to IDLE.
  - GAP: lines high for GAP_CYC cycles, then byte++, bit=0, and go to BIT_HI.
- Data changes only on entry to BIT_HI, never while ps2_clk_o=0. The host samples on the falling edge.
- Latency: ps2_data_o falls to the start bit on the first edge after the acceptance edge.
- Sequence length: busy is high for exactly 66*CLK_DIV + 2*GAP_CYC cycles; ready returns high on the cycle the final BIT_LO ends.
- Counters: divider is 16 bits and wraps to 0 at each phase change. Bit counter 0..10. Byte counter 0..2, never wraps past 2.

Decomposition:
- Package letter_ps2_pkg holds:
  - the 26-entry scan code table, as a function letter→code plus a valid flag;
  - constant BREAK_PREFIX = 8'hF0;
  - FSM state enum;
  - frame length constant 11.
- Sub-module ps2_byte_ser is a single-byte 11-bit serializer with start/done handshake and its own CLK_DIV divider.
- The top level holds the table lookup, the 3-byte sequencer, GAP timing, and the valid/ready/err logic.

Test Plan:
- Set CLK_DIV=4, GAP_CYC=8, letter=1 (A) with valid for 1 cycle → three frames, bytes 1C, F0, 1C.
  - The 1C frame is 0,0,0,1,1,1,0,0,0,0(parity),1; the F0 parity bit is 1.
  - busy is high for 280 cycles, then ready=1.
- Letter=5 (E, 24) → bits after start are 0,0,1,0,0,1,0,0 and parity=1. Decode the stream with a falling-edge PS/2 monitor, then map it back through a scan-code-to-letter decoder → 5.
- Letter=0, then letter=27, each with valid → err pulses 1 cycle each, ps2_clk_o/ps2_data_o stay 1, ready stays 1.
- Send letter=26 (Z), and pulse valid with letter=3 at cycle 50 while busy → only 1A, F0, 1A is transmitted, no err, and ready=1 only after the Z sequence ends.
- Assert rst_n=0 during the F0 frame (bit 4) → lines high and ready=1 within the same cycle. After release, letter=17 (Q) transmits 15, F0, 15 cleanly.
- Sweep letters 1..26 back-to-back, reasserting valid as soon as ready rises → every decoded make code matches the table, and every byte has odd total parity.
